// File: rtl/mux2x1_serial_capture.sv
// Assembles WIDTH serial y bits (MSB first) into a word; data_valid rises on the edge sampling the last bit.
// One-word output slot: if it is still full at completion, the word waits in HOLD and extra bits flag overrun.
module mux2x1_serial_capture #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             y_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic [CW-1:0]    bit_count,
  output logic             overrun
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n, data_out_n, shifted;
  logic [CW-1:0]    bit_count_n;
  logic             data_valid_n, overrun_n, busy_n;

  assign shifted = {sr[WIDTH-2:0], y_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sr         <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      bit_count  <= '0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      sr         <= sr_n;
      data_out   <= data_out_n;
      data_valid <= data_valid_n;
      bit_count  <= bit_count_n;
      overrun    <= overrun_n;
      busy       <= busy_n;
    end
  end

  always_comb begin
    state_n      = state;
    sr_n         = sr;
    data_out_n   = data_out;
    data_valid_n = data_valid;
    bit_count_n  = bit_count;
    overrun_n    = overrun;
    // A transfer empties the slot unless a new word is loaded below on the same edge.
    if (data_valid && data_ready) data_valid_n = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n     = SHIFT;
          sr_n        = '0;
          bit_count_n = '0;
          overrun_n   = 1'b0;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          sr_n = shifted;
          if (bit_count == CW'(WIDTH - 1)) begin
            if (!data_valid || data_ready) begin
              data_out_n   = shifted;
              data_valid_n = 1'b1;
              state_n      = IDLE;
              bit_count_n  = '0;
            end else begin
              state_n     = HOLD;
              bit_count_n = CW'(WIDTH);
            end
          end else begin
            bit_count_n = bit_count + 1'b1;
          end
        end
      end
      HOLD: begin
        if (bit_valid) overrun_n = 1'b1;
        if (data_ready) begin
          data_out_n   = sr;
          data_valid_n = 1'b1;
          state_n      = IDLE;
          bit_count_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_mux2x1_serial_capture.sv
// Bench for mux2x1_serial_capture: directed scenarios plus random traffic against a word-level model.
module tb_mux2x1_serial_capture;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst, start, y_in, bit_valid, data_ready;
  logic [WIDTH-1:0] data_out;
  logic             data_valid, busy, overrun;
  logic [CW-1:0]    bit_count;

  mux2x1_serial_capture #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .y_in(y_in), .bit_valid(bit_valid),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .busy(busy), .bit_count(bit_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Word-level model: capturing/holding flags, accumulated value, output slot.
  bit               m_cap, m_hold, m_valid, m_ovr;
  int               m_cnt;
  logic [WIDTH-1:0] m_acc, m_out;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    bit slot_full;
    slot_full = m_valid && !data_ready;
    if (rst) begin
      m_cap = 0; m_hold = 0; m_valid = 0; m_ovr = 0; m_cnt = 0; m_acc = '0; m_out = '0;
    end else if (m_hold) begin
      if (bit_valid) m_ovr = 1;
      if (data_ready) begin
        m_out = m_acc; m_valid = 1; m_hold = 0; m_cnt = 0;
      end
    end else begin
      if (m_valid && data_ready) m_valid = 0;
      if (m_cap) begin
        if (bit_valid) begin
          m_acc = (m_acc << 1) | WIDTH'(y_in);
          m_cnt = m_cnt + 1;
          if (m_cnt == WIDTH) begin
            m_cap = 0;
            if (!slot_full) begin
              m_out = m_acc; m_valid = 1; m_cnt = 0;
            end else begin
              m_hold = 1;
            end
          end
        end
      end else if (start) begin
        m_cap = 1; m_acc = '0; m_cnt = 0; m_ovr = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("data_out", data_out, m_out);
    chk("data_valid", data_valid, m_valid);
    chk("busy", busy, m_cap || m_hold);
    chk("bit_count", bit_count, m_cnt);
    chk("overrun", overrun, m_ovr);
  endtask

  // gap_at: bit index before which bit_valid drops for gap_len cycles (start pulsed in gap if gap_start).
  task automatic send_word(input logic [WIDTH-1:0] w, input int gap_at, input int gap_len,
                           input bit gap_start);
    start = 1; bit_valid = 0;
    step();
    start = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          bit_valid = 0; start = gap_start; y_in = 1'($urandom);
          step();
          chk("gap_bit_count", bit_count, gap_at);
        end
        start = 0;
      end
      bit_valid = 1; y_in = w[WIDTH-1-i];
      step();
    end
    bit_valid = 0;
  endtask

  initial begin
    start = 0; y_in = 0; bit_valid = 0; data_ready = 0;

    // 1: reset with random inputs
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom); y_in = 1'($urandom); bit_valid = 1'($urandom); data_ready = 1'($urandom);
      step();
    end
    chk("reset_data_out", data_out, 0);
    chk("reset_valid", data_valid, 0);
    rst = 0; start = 0; bit_valid = 0; data_ready = 1;
    step();

    // 2: basic capture
    send_word(8'hB2, -1, 0, 0);
    chk("basic_word", data_out, 8'hB2);
    chk("basic_valid", data_valid, 1);
    chk("basic_busy", busy, 0);
    step();
    chk("basic_valid_drop", data_valid, 0);

    // 3: gap of three cycles between bits 4 and 5
    send_word(8'hB2, 4, 3, 0);
    chk("gap_word", data_out, 8'hB2);
    step();

    // 4: backpressure and overrun
    data_ready = 0;
    send_word(8'hB2, -1, 0, 0);
    send_word(8'h5A, -1, 0, 0);
    chk("bp_hold_busy", busy, 1);
    chk("bp_hold_count", bit_count, WIDTH);
    bit_valid = 1; y_in = 1;
    step();
    bit_valid = 0;
    step(); step();
    chk("bp_overrun", overrun, 1);
    chk("bp_stable", data_out, 8'hB2);
    chk("bp_busy", busy, 1);
    data_ready = 1;
    step();
    chk("bp_second_word", data_out, 8'h5A);
    chk("bp_second_valid", data_valid, 1);
    step();
    chk("bp_drain", data_valid, 0);

    // 5: reset mid-word
    start = 1; step(); start = 0;
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1; y_in = 1; step();
    end
    bit_valid = 0; rst = 1;
    step();
    chk("midrst_count", bit_count, 0);
    chk("midrst_busy", busy, 0);
    rst = 0;
    send_word(8'h0F, -1, 0, 0);
    chk("midrst_word", data_out, 8'h0F);
    step();

    // 6: start during SHIFT is ignored
    send_word(8'hC3, 2, 1, 1);
    chk("start_ignored_word", data_out, 8'hC3);
    step();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      rst        = ($urandom_range(0, 99) < 2);
      start      = ($urandom_range(0, 99) < 25);
      bit_valid  = ($urandom_range(0, 99) < 70);
      data_ready = ($urandom_range(0, 99) < 50);
      y_in       = 1'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
